sdram_arbit_ctrl: RTL and testbench

//   Owns the single SDRAM command/address/data bus after power-up. Passes the init

---
 rtl/sdram_pkg.sv | 44 ++++
 rtl/sdram_arb_mux.sv | 55 +++++
 rtl/sdram_arbit_ctrl.sv | 132 +++++++++++++
 tb/tb_sdram_arbit_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared encodings for the SDRAM bus arbiter: command codes, arbiter states, bus-select codes.
package sdram_pkg;

    localparam int unsigned DEF_ADDR_W = 12;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned CMD_W      = 4;
    localparam int unsigned BA_W       = 2;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] SDRAM_NOP      = 4'b0111;
    localparam logic [3:0] SDRAM_P_CHARGE = 4'b0010;
    localparam logic [3:0] SDRAM_A_REF    = 4'b0001;
    localparam logic [3:0] SDRAM_ACTIVE   = 4'b0011;
    localparam logic [3:0] SDRAM_WRITE    = 4'b0100;
    localparam logic [3:0] SDRAM_READ     = 4'b0101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_e;

    typedef enum logic [2:0] {
        SEL_INIT = 3'd0,
        SEL_AREF = 3'd1,
        SEL_WR   = 3'd2,
        SEL_RD   = 3'd3,
        SEL_NOP  = 3'd4
    } bus_sel_e;

    // Which engine owns the pins in a given arbiter state.
    function automatic bus_sel_e state_to_sel(input arb_state_e st);
        case (st)
            ST_IDLE:  state_to_sel = SEL_INIT;
            ST_AREF:  state_to_sel = SEL_AREF;
            ST_WRITE: state_to_sel = SEL_WR;
            ST_READ:  state_to_sel = SEL_RD;
            default:  state_to_sel = SEL_NOP;
        endcase
    endfunction

endpackage

// File: rtl/sdram_arb_mux.sv
// Combinational 4:1 select of engine command/bank/address onto the SDRAM pins, NOP otherwise.
module sdram_arb_mux
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter logic [3:0]  NOP_CMD = SDRAM_NOP
) (
    input  bus_sel_e          sel,
    input  logic [3:0]        init_cmd,
    input  logic [1:0]        init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [3:0]        aref_cmd,
    input  logic [1:0]        aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic [3:0]        wr_cmd,
    input  logic [1:0]        wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        rd_cmd,
    input  logic [1:0]        rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        sel_cmd,
    output logic [1:0]        sel_ba,
    output logic [ADDR_W-1:0] sel_addr
);

    always_comb begin
        sel_cmd  = NOP_CMD;
        sel_ba   = 2'b11;
        sel_addr = {ADDR_W{1'b1}};
        case (sel)
            SEL_INIT: begin
                sel_cmd  = init_cmd;
                sel_ba   = init_ba;
                sel_addr = init_addr;
            end
            SEL_AREF: begin
                sel_cmd  = aref_cmd;
                sel_ba   = aref_ba;
                sel_addr = aref_addr;
            end
            SEL_WR: begin
                sel_cmd  = wr_cmd;
                sel_ba   = wr_ba;
                sel_addr = wr_addr;
            end
            SEL_RD: begin
                sel_cmd  = rd_cmd;
                sel_ba   = rd_ba;
                sel_addr = rd_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sdram_arbit_ctrl.sv
// SDRAM bus arbiter: init pass-through, then refresh > write > read grants held until *_end.
// Optional SDRAM_ARB_RR_EN: alternate write/read priority when both request.
module sdram_arbit_ctrl
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter logic [3:0]  CMD_NOP = SDRAM_NOP
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [3:0]        init_cmd,
    input  logic [1:0]        init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              init_end,
    input  logic              aref_req,
    input  logic [3:0]        aref_cmd,
    input  logic [1:0]        aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              aref_end,
    input  logic              wr_req,
    input  logic [3:0]        wr_cmd,
    input  logic [1:0]        wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_sdram_en,
    input  logic [DATA_W-1:0] wr_sdram_data,
    input  logic              wr_end,
    input  logic              rd_req,
    input  logic [3:0]        rd_cmd,
    input  logic [1:0]        rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_end,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [1:0]        sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DATA_W-1:0] sdram_dq_out,
    output logic              sdram_dq_oe
);

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic              rd_first;
    logic [3:0]        sel_cmd;

`ifdef SDRAM_ARB_RR_EN
    logic rr_rd_first;

    // Flips after every completed write or read burst; 0 means write wins a tie.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rr_rd_first <= 1'b0;
        end else if ((state == ST_WRITE && wr_end) || (state == ST_READ && rd_end)) begin
            rr_rd_first <= ~rr_rd_first;
        end
    end

    assign rd_first = rr_rd_first;
`else
    assign rd_first = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grants always return through ARBIT, so back-to-back bursts see at least one NOP.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (init_end) state_nxt = ST_ARBIT;
            end
            ST_ARBIT: begin
                if (aref_req)                           state_nxt = ST_AREF;
                else if (wr_req && !(rd_req && rd_first)) state_nxt = ST_WRITE;
                else if (rd_req)                        state_nxt = ST_READ;
            end
            ST_AREF: begin
                if (aref_end) state_nxt = ST_ARBIT;
            end
            ST_WRITE: begin
                if (wr_end) state_nxt = ST_ARBIT;
            end
            ST_READ: begin
                if (rd_end) state_nxt = ST_ARBIT;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign aref_en = (state == ST_AREF);
    assign wr_en   = (state == ST_WRITE);
    assign rd_en   = (state == ST_READ);

    assign sdram_dq_oe  = (state == ST_WRITE) && wr_sdram_en;
    assign sdram_dq_out = sdram_dq_oe ? wr_sdram_data : {DATA_W{1'b0}};

    sdram_arb_mux #(
        .ADDR_W  (ADDR_W),
        .NOP_CMD (CMD_NOP)
    ) u_mux (
        .sel       (state_to_sel(state)),
        .init_cmd  (init_cmd),
        .init_ba   (init_ba),
        .init_addr (init_addr),
        .aref_cmd  (aref_cmd),
        .aref_ba   (aref_ba),
        .aref_addr (aref_addr),
        .wr_cmd    (wr_cmd),
        .wr_ba     (wr_ba),
        .wr_addr   (wr_addr),
        .rd_cmd    (rd_cmd),
        .rd_ba     (rd_ba),
        .rd_addr   (rd_addr),
        .sel_cmd   (sel_cmd),
        .sel_ba    (sdram_ba),
        .sel_addr  (sdram_addr)
    );

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = sel_cmd;

endmodule

// File: tb/tb_sdram_arbit_ctrl.sv
// Directed self-checking bench for sdram_arbit_ctrl (honours SDRAM_ARB_RR_EN when defined).
module tb_sdram_arbit_ctrl;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 16;

    logic              sys_clk;
    logic              sys_rst;
    logic [3:0]        init_cmd;
    logic [1:0]        init_ba;
    logic [ADDR_W-1:0] init_addr;
    logic              init_end;
    logic              aref_req;
    logic [3:0]        aref_cmd;
    logic [1:0]        aref_ba;
    logic [ADDR_W-1:0] aref_addr;
    logic              aref_end;
    logic              wr_req;
    logic [3:0]        wr_cmd;
    logic [1:0]        wr_ba;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_sdram_en;
    logic [DATA_W-1:0] wr_sdram_data;
    logic              wr_end;
    logic              rd_req;
    logic [3:0]        rd_cmd;
    logic [1:0]        rd_ba;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_end;
    logic              aref_en;
    logic              wr_en;
    logic              rd_en;
    logic              sdram_cs_n;
    logic              sdram_ras_n;
    logic              sdram_cas_n;
    logic              sdram_we_n;
    logic [1:0]        sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;
    logic [DATA_W-1:0] sdram_dq_out;
    logic              sdram_dq_oe;

    int checks   = 0;
    int failures = 0;

    sdram_arbit_ctrl dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .init_cmd      (init_cmd),
        .init_ba       (init_ba),
        .init_addr     (init_addr),
        .init_end      (init_end),
        .aref_req      (aref_req),
        .aref_cmd      (aref_cmd),
        .aref_ba       (aref_ba),
        .aref_addr     (aref_addr),
        .aref_end      (aref_end),
        .wr_req        (wr_req),
        .wr_cmd        (wr_cmd),
        .wr_ba         (wr_ba),
        .wr_addr       (wr_addr),
        .wr_sdram_en   (wr_sdram_en),
        .wr_sdram_data (wr_sdram_data),
        .wr_end        (wr_end),
        .rd_req        (rd_req),
        .rd_cmd        (rd_cmd),
        .rd_ba         (rd_ba),
        .rd_addr       (rd_addr),
        .rd_end        (rd_end),
        .aref_en       (aref_en),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .sdram_cs_n    (sdram_cs_n),
        .sdram_ras_n   (sdram_ras_n),
        .sdram_cas_n   (sdram_cas_n),
        .sdram_we_n    (sdram_we_n),
        .sdram_ba      (sdram_ba),
        .sdram_addr    (sdram_addr),
        .sdram_dq_out  (sdram_dq_out),
        .sdram_dq_oe   (sdram_dq_oe)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grants as {aref_en, wr_en, rd_en}.
    task automatic chk_grants(input string tag, input logic [2:0] exp);
        chk(tag, 32'({aref_en, wr_en, rd_en}), 32'(exp));
    endtask

    // Pins as {cmd[3:0], ba[1:0], addr[11:0]}.
    task automatic chk_pins(input string tag, input logic [3:0] cmd, input logic [1:0] ba,
                            input logic [ADDR_W-1:0] addr);
        chk(tag, 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr}),
            32'({cmd, ba, addr}));
    endtask

    task automatic chk_dq(input string tag, input logic oe, input logic [DATA_W-1:0] data);
        chk(tag, 32'({sdram_dq_oe, sdram_dq_out}), 32'({oe, data}));
    endtask

    initial begin
        logic       exp_rd;
        logic [2:0] exp_g;

        sys_rst       = 1'b1;
        init_cmd      = 4'b0010;
        init_ba       = 2'b01;
        init_addr     = 12'h400;
        init_end      = 1'b0;
        aref_req      = 1'b0;
        aref_cmd      = 4'b0001;
        aref_ba       = 2'b10;
        aref_addr     = 12'h0A5;
        aref_end      = 1'b0;
        wr_req        = 1'b0;
        wr_cmd        = 4'b0100;
        wr_ba         = 2'b01;
        wr_addr       = 12'h123;
        wr_sdram_en   = 1'b1;
        wr_sdram_data = 16'hBEEF;
        wr_end        = 1'b0;
        rd_req        = 1'b0;
        rd_cmd        = 4'b0101;
        rd_ba         = 2'b10;
        rd_addr       = 12'h321;
        rd_end        = 1'b0;

        tick();
        tick();
        chk_grants("rst_grants", 3'b000);
        chk_pins("rst_pins", 4'b0010, 2'b01, 12'h400);
        chk_dq("rst_dq", 1'b0, 16'h0000);

        sys_rst = 1'b0;
        repeat (10) tick();
        chk_pins("idle_pins", 4'b0010, 2'b01, 12'h400);
        chk_grants("idle_grants", 3'b000);

        init_end = 1'b1;
        tick();
        chk_pins("arbit_nop", 4'b0111, 2'b11, 12'hFFF);
        chk_grants("arbit_grants", 3'b000);

        init_end = 1'b0;
        tick();
        chk_pins("init_drop_ignored", 4'b0111, 2'b11, 12'hFFF);
        init_end = 1'b1;

        aref_req = 1'b1;
        wr_req   = 1'b1;
        rd_req   = 1'b1;
        tick();
        chk_grants("pri_aref", 3'b100);
        chk_pins("aref_pins", 4'b0001, 2'b10, 12'h0A5);
        chk_dq("dq_in_aref", 1'b0, 16'h0000);

        aref_req = 1'b0;
        tick();
        chk_grants("aref_hold", 3'b100);

        aref_end = 1'b1;
        tick();
        aref_end = 1'b0;
        chk_grants("aref_end_arbit", 3'b000);
        chk_pins("aref_end_nop", 4'b0111, 2'b11, 12'hFFF);

        tick();
        chk_grants("pri_wr", 3'b010);
        chk_pins("wr_pins", 4'b0100, 2'b01, 12'h123);
        chk_dq("dq_on", 1'b1, 16'hBEEF);
        wr_sdram_en = 1'b0;
        #1;
        chk_dq("dq_off", 1'b0, 16'h0000);

        aref_req = 1'b1;
        rd_end   = 1'b1;
        tick();
        rd_end = 1'b0;
        chk_grants("wr_hold", 3'b010);

        wr_sdram_en = 1'b1;
        wr_end      = 1'b1;
        tick();
        wr_end = 1'b0;
        chk_grants("wr_end_arbit", 3'b000);
        chk_dq("dq_arbit", 1'b0, 16'h0000);

        tick();
        chk_grants("aref_after_wr", 3'b100);

        aref_req = 1'b0;
        aref_end = 1'b1;
        tick();
        aref_end = 1'b0;
        chk_grants("aref2_end", 3'b000);

        // Reset again so the write/read tie-break starts from its reset value.
        sys_rst = 1'b1;
        tick();
        chk_grants("rst2_grants", 3'b000);
        chk_pins("rst2_pins", 4'b0010, 2'b01, 12'h400);
        sys_rst = 1'b0;
        tick();
        chk_pins("rst2_arbit", 4'b0111, 2'b11, 12'hFFF);

        for (int i = 0; i < 4; i++) begin
`ifdef SDRAM_ARB_RR_EN
            exp_rd = (i % 2 == 1);
`else
            exp_rd = 1'b0;
`endif
            exp_g = exp_rd ? 3'b001 : 3'b010;
            tick();
            chk_grants($sformatf("tie_burst%0d", i), exp_g);
            if (exp_rd) rd_end = 1'b1;
            else        wr_end = 1'b1;
            tick();
            rd_end = 1'b0;
            wr_end = 1'b0;
            chk_grants($sformatf("tie_gap%0d", i), 3'b000);
        end

        wr_req = 1'b0;
        tick();
        chk_grants("rd_grant", 3'b001);
        chk_pins("rd_pins", 4'b0101, 2'b10, 12'h321);

        sys_rst = 1'b1;
        tick();
        chk_grants("rst_in_read", 3'b000);
        chk_pins("rst_in_read_pins", 4'b0010, 2'b01, 12'h400);
        sys_rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
